rom_loader: RTL

Program loader that sits directly upstream of the 16-chip ROM bank. It accepts a byte stream over a valid/ready handshake and packs each byte pair into a 16-bit word, high byte first. Each word is written into consecutive ROM columns starting at a programmable base, by driving the bank's column_id, in and mode inputs. After the last write it reports completion and a 16-bit checksum of the words written.

---
 rtl/rom_pkg.sv | 37 +++
 rtl/rom_loader_if.sv | 32 +++
 rtl/rom_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the ROM bank and its program loader: bank mode
// encodings, column address split and loader state encoding.
package rom_pkg;

  localparam int ROM_ADDR_W = 11;
  localparam int CS_MSB     = 10;
  localparam int CS_LSB     = 7;
  localparam int IN_MSB     = 6;
  localparam int IN_LSB     = 0;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Column address -> chip select of the 16-chip bank.
  function automatic logic [CS_MSB-CS_LSB:0] chip_sel(input logic [ROM_ADDR_W-1:0] addr);
    return addr[CS_MSB:CS_LSB];
  endfunction

  // Column address -> row inside the selected chip.
  function automatic logic [IN_MSB-IN_LSB:0] in_chip(input logic [ROM_ADDR_W-1:0] addr);
    return addr[IN_MSB:IN_LSB];
  endfunction

  // Running checksum of written words, modulo 2^16.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM bank write port of the program loader.
// master = the loader, slave = the byte source / ROM bank side.
interface rom_loader_if #(
  parameter int ADDR_W = 11
);

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] column_id;
  logic [15:0]       data;
  logic [1:0]        mode;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output column_id,
    output data,
    output mode
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  column_id,
    input  data,
    input  mode
  );

endinterface

// File: rtl/rom_loader.sv
// Program loader: packs a byte stream into 16-bit words (high byte first)
// and writes them to consecutive ROM columns, reporting a checksum at the end.
module rom_loader
  import rom_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  rom_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum,
  output logic              wrapped
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  remaining_r;
  logic [7:0]        word_hi_r;
  logic [15:0]       data_r;
  logic [ADDR_W-1:0] column_id_r;
  logic [1:0]        mode_r;
  logic              byte_ready_r;
  logic              busy_r;
  logic              done_r;
  logic [15:0]       checksum_r;
  logic              wrapped_r;

  // Next-state decode; start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_nxt_s = ST_FIN;
          end else begin
            state_nxt_s = ST_HI;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HI: begin
        if (bus.byte_valid) begin
          state_nxt_s = ST_LO;
        end else begin
          state_nxt_s = ST_HI;
        end
      end
      ST_LO: begin
        if (bus.byte_valid) begin
          state_nxt_s = ST_WR;
        end else begin
          state_nxt_s = ST_LO;
        end
      end
      ST_WR: begin
        if (remaining_r == CNT_W'(1)) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_HI;
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Load bookkeeping and word packing; a half-built word is simply dropped on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_r      <= '0;
      remaining_r <= '0;
      word_hi_r   <= 8'h00;
      data_r      <= 16'h0000;
      column_id_r <= '0;
      checksum_r  <= 16'h0000;
      wrapped_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (count != '0)) begin
            addr_r      <= base;
            remaining_r <= count;
            checksum_r  <= 16'h0000;
            wrapped_r   <= 1'b0;
          end
        end
        ST_HI: begin
          if (bus.byte_valid) begin
            word_hi_r <= bus.byte_in;
          end
        end
        ST_LO: begin
          // The write port is loaded as the low byte arrives so WR drives it directly.
          if (bus.byte_valid) begin
            data_r      <= {word_hi_r, bus.byte_in};
            column_id_r <= addr_r;
          end
        end
        ST_WR: begin
          checksum_r  <= csum_add(checksum_r, data_r);
          addr_r      <= addr_r + ADDR_W'(1);
          remaining_r <= remaining_r - CNT_W'(1);
          if (addr_r == {ADDR_W{1'b1}}) begin
            wrapped_r <= 1'b1;
          end
        end
        ST_FIN: begin
          remaining_r <= '0;
        end
        default: begin
          remaining_r <= '0;
        end
      endcase
    end
  end

  // Handshake and status outputs registered from the upcoming state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_ready_r <= 1'b0;
      mode_r       <= MODE_READ;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      byte_ready_r <= (state_nxt_s == ST_HI) || (state_nxt_s == ST_LO);
      mode_r       <= (state_nxt_s == ST_WR) ? MODE_WRITE : MODE_READ;
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= (state_nxt_s == ST_FIN);
    end
  end

  assign bus.byte_ready = byte_ready_r;
  assign bus.column_id  = column_id_r;
  assign bus.data       = data_r;
  assign bus.mode       = mode_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign checksum       = checksum_r;
  assign wrapped        = wrapped_r;

endmodule
